// File: rtl/sample_capture_pkg.sv
// -----------------------------------------------------------------------------
// sample_capture_pkg
// Shared definitions for the sample capture block. It holds the capture FSM
// state encoding and the default sizing constants used by sample_capture and
// capture_fifo.
// -----------------------------------------------------------------------------
package sample_capture_pkg;

   localparam int DEF_DW          = 16;   // sample word width
   localparam int DEF_DEPTH       = 4;    // capture FIFO depth (power of two, >= 2)
   localparam int DEF_NUM_SAMPLES = 16;   // samples taken per capture run

   // Capture sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // waiting for arm
      ST_START = 2'd1,   // timer start pulse being issued
      ST_RUN   = 2'd2,   // taking samples on each timer tick
      ST_DRAIN = 2'd3    // all samples taken, waiting for FIFO to empty
   } cap_state_t;

endpackage : sample_capture_pkg

// File: rtl/capture_fifo.sv
// -----------------------------------------------------------------------------
// capture_fifo
// First-word-fall-through FIFO holding captured samples. A word pushed on an
// edge appears on dout/!empty right after that edge. dout is a register: it
// holds the last head value while the FIFO is empty and resets to zero.
// full and empty are registered flags.
//
// Ports
//   clk    in   clock, all logic on posedge
//   rstn   in   synchronous active-low reset, empties the FIFO
//   push   in   write din (ignored when full, unless popping in the same cycle)
//   pop    in   remove head word (ignored when empty)
//   din    in   DW  write data
//   dout   out  DW  head word
//   full   out  occupancy == DEPTH
//   empty  out  occupancy == 0
//   level  out  clog2(DEPTH+1)  occupancy
// -----------------------------------------------------------------------------
module capture_fifo
   import sample_capture_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         push,
   input  logic                         pop,
   input  logic [DW-1:0]                din,
   output logic [DW-1:0]                dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_nxt;
   logic [LW-1:0] level_nxt;
   logic          do_push;
   logic          do_pop;

   // A full FIFO still accepts a write when the head leaves on the same edge;
   // in that case wr_ptr == rd_ptr and the old head slot is reused.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_nxt  = rd_ptr + 1'b1;

   always_comb begin
      level_nxt = level;
      case ({do_push, do_pop})
         2'b10:   level_nxt = level + 1'b1;
         2'b01:   level_nxt = level - 1'b1;
         default: level_nxt = level;
      endcase
   end

   // Storage has no reset: contents are only visible through dout, which is.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         dout   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_nxt;
         level <= level_nxt;
         full  <= (level_nxt == LW'(DEPTH));
         empty <= (level_nxt == '0);

         // Registered head: load whatever becomes the head after this edge.
         // When the last word leaves and nothing arrives, dout keeps it.
         if (do_pop) begin
            if (level >= LW'(2))
               dout <= mem[rd_nxt];   // next stored word becomes head
            else if (do_push)
               dout <= din;           // sole word replaced in the same cycle
         end else if (empty && do_push) begin
            dout <= din;              // first word into an empty FIFO
         end
      end
   end

endmodule : capture_fifo

// File: rtl/sample_capture.sv
// -----------------------------------------------------------------------------
// sample_capture
// Sequences one capture run: on arm it pulses start to kick the period timer,
// then on every update_flag tick it pushes sample_in into the capture FIFO and
// re-arms the timer with another start pulse, until NUM_SAMPLES samples have
// been taken. It then waits for the consumer to drain the FIFO and pulses done.
// Samples arriving to a full FIFO are dropped, flagged by the sticky overflow,
// and still count toward the run length.
//
// Ports
//   clk          in   clock, all logic on posedge
//   rstn         in   synchronous active-low reset, priority over en
//   en           in   block enable; low freezes all state, gates start/done
//   arm          in   begin a run (only seen in IDLE)
//   update_flag  in   timer period tick (only seen in RUN)
//   sample_in    in   DW  word captured on update_flag
//   start        out  one-cycle timer (re)start pulse
//   out_data     out  DW  FIFO head word
//   out_valid    out  FIFO non-empty
//   out_ready    in   consumer accepts head
//   busy         out  sequencer not in IDLE
//   done         out  one-cycle pulse at run completion
//   overflow     out  sticky sample-dropped flag, cleared by arm
//   level        out  clog2(DEPTH+1)  FIFO occupancy
// -----------------------------------------------------------------------------
module sample_capture
   import sample_capture_pkg::*;
#(
   parameter int DW          = DEF_DW,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         en,
   input  logic                         arm,
   input  logic                         update_flag,
   input  logic [DW-1:0]                sample_in,
   output logic                         start,
   output logic [DW-1:0]                out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         busy,
   output logic                         done,
   output logic                         overflow,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int CW = $clog2(NUM_SAMPLES+1);

   cap_state_t    state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          start_q;
   logic          done_q;
   logic          busy_q;
   logic          ovf_q;

   logic          fifo_full;
   logic          fifo_empty;
   logic          sample;
   logic          pop;
   logic          drop;

   // A sample is taken only on a tick inside RUN while enabled.
   assign sample  = en && (state == ST_RUN) && update_flag;
   // The consumer may drain in any state.
   assign pop     = en && !fifo_empty && out_ready;
   // A push to a full FIFO survives only if the head leaves on the same edge.
   assign drop    = sample && fifo_full && !pop;
   assign cnt_inc = cnt + 1'b1;

   capture_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (sample),
      .pop   (pop),
      .din   (sample_in),
      .dout  (out_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // Sequencer. Every registered output is written alongside its transition.
   // With en low nothing moves, so a pending start/done pulse is held and
   // surfaces once the block is re-enabled.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (en) begin
         start_q <= 1'b0;
         done_q  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (arm) begin
                  state   <= ST_START;
                  cnt     <= '0;
                  ovf_q   <= 1'b0;
                  start_q <= 1'b1;   // high for the whole START cycle
                  busy_q  <= 1'b1;
               end
            end
            ST_START: begin
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (update_flag) begin
                  cnt <= cnt_inc;
                  if (drop) ovf_q <= 1'b1;
                  // Re-arm the timer unless this was the final sample.
                  if (cnt_inc < CW'(NUM_SAMPLES))
                     start_q <= 1'b1;
                  else
                     state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (fifo_empty) begin
                  state  <= ST_IDLE;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Pulses are suppressed while disabled.
   assign start     = start_q && en;
   assign done      = done_q && en;
   assign busy      = busy_q;
   assign overflow  = ovf_q;
   assign out_valid = !fifo_empty;

endmodule : sample_capture

// File: doc/sample_capture.md
SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 Parameter DW, default 16: sample word width in bits.
REQ-002 Parameter DEPTH, default 4: capture FIFO depth in words, power of two, at least 2.
REQ-003 Parameter NUM_SAMPLES, default 16: samples per run, at least 1.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  block enable; low freezes all state.
REQ-007 arm  input  1  request to begin a capture run.
REQ-008 update_flag  input  1  period tick from timer, one-cycle pulse.
REQ-009 sample_in  input  DW  data word sampled on update_flag.
REQ-010 start  output  1  one-cycle pulse that (re)starts the timer.
REQ-011 out_data  output  DW  FIFO head word.
REQ-012 out_valid  output  1  FIFO non-empty.
REQ-013 out_ready  input  1  consumer accepts head; pop when out_valid && out_ready.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse at run completion.
REQ-016 overflow  output  1  sticky; a sample was dropped because the FIFO was full.
REQ-017 level  output  clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-018 FSM states: IDLE, START, RUN, DRAIN; all transitions require en=1.
REQ-019 IDLE: arm=1 -> START; clears the sample count and overflow on that edge.
REQ-020 START: start=1 for exactly this one cycle; -> RUN next cycle.
REQ-021 RUN, update_flag=1:
  - push sample_in and increment the sample count;
  - if the new count < NUM_SAMPLES, assert start on the next cycle (registered re-arm) and stay in RUN;
  - else -> DRAIN, with no further start.
REQ-022 DRAIN: when the FIFO is empty (level=0) -> IDLE with done=1 for one cycle.
REQ-023 Ignore arm outside IDLE; ignore update_flag in IDLE, START and DRAIN.
REQ-024 FIFO full:
  - a push with no simultaneous pop drops the word, sets overflow, and still counts toward NUM_SAMPLES;
  - a push and pop in the same cycle while full is accepted, and level is unchanged.
REQ-025 FIFO empty: out_valid=0, out_data holds its last value, and out_ready is ignored.
REQ-026 First-word-fall-through: a pushed word is visible on out_data/out_valid one cycle after the push edge.
REQ-027 Sample count width is clog2(NUM_SAMPLES+1); FIFO pointers wrap modulo DEPTH.
REQ-028 en=0:
  - no state change, no push, no pop;
  - start=0 and done=0;
  - other outputs hold;
  - an update_flag arriving during en=0 is lost.
REQ-029 Pops are permitted in every state, including IDLE, while data remains.

Reset
REQ-030 rstn=0 at a posedge: FSM -> IDLE; FIFO emptied; count=0; start=0, out_valid=0, out_data=0, busy=0, done=0, overflow=0, level=0.
REQ-031 Reset mid-run discards all buffered data; no done pulse is generated.
REQ-032 Reset has priority over en.

Structure
REQ-033 A shared package holds the FSM state enumeration and the default DW, DEPTH and NUM_SAMPLES constants.
REQ-034 The FIFO is a sub-module, capture_fifo (DW, DEPTH):
  - push/pop/full/empty/level;
  - same clk/rstn;
  - full and empty flags registered.
REQ-035 The FSM, counter and start re-arm logic reside in sample_capture.

Verification
REQ-036 Scenario, basic run: NUM_SAMPLES=3, DEPTH=4, out_ready=1, arm pulse, update_flag every 10 cycles with sample_in=0x0011, 0x0022, 0x0033.
  - Required: start one cycle after arm and one cycle after each of the first two update_flags (3 start pulses total);
  - out_data sequence 0x0011, 0x0022, 0x0033;
  - done once, then busy=0.
REQ-037 Scenario, overflow: NUM_SAMPLES=6, DEPTH=4, out_ready=0, six update_flags.
  - Required: level saturates at 4 and overflow=1;
  - after out_ready=1, four words are drained (the first four samples), then done=1.
REQ-038 Scenario, full FIFO with simultaneous push and pop: FIFO full, update_flag and out_ready=1 in the same cycle.
  - Required: level stays 4, no overflow, and the new word is the last one out.
REQ-039 Scenario, enable freeze: en=0 for 5 cycles in RUN with update_flag pulsed.
  - Required: level, count and state are unchanged and no start is issued;
  - after en=1 the run resumes on the next update_flag.
REQ-040 Scenario, reset mid-run: rstn=0 for one edge with level=2 in RUN.
  - Required: all outputs at their reset values the next cycle and no done pulse;
  - a subsequent arm starts a clean run.
REQ-041 Scenario, ignored inputs: arm during RUN and update_flag during IDLE.
  - Required: no state change and no start pulse.
